onchip_mem_test_master: RTL and testbench
=========================================

# onchip_mem_test_master

Avalon-MM master that fills a region of the 32-bit single-port on-chip memory with a deterministic pattern, reads it back and reports mismatches. It connects to the memory's Avalon slave through the system interconnect and drives the memory's write path and read path, with waitrequest and readdatavalid honoured. It serves as the power-on and debug test engine for on-chip RAM.

## Interface
- ADDR_W, 10, word-address width of the target memory (1024 words)
- DATA_W, 32, data width; fixed at 32, byteenable is 4 bits
- clk  in  1  system clock; all logic is on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; accepted only in IDLE
- base_addr  in  ADDR_W  first word address of the region; sampled at start
- length  in  ADDR_W+1  word count, 0..2^ADDR_W; sampled at start
- seed  in  32  pattern seed; sampled at start
- busy  out  1  high in WRITE, READ_REQ, READ_WAIT
- done  out  1  one-cycle pulse at end of test
- pass  out  1  1 if error_count==0; updated in DONE
- error_count  out  16  mismatching words; saturates at 0xFFFF
- first_err_addr  out  ADDR_W  word address of the first mismatch; 0 if none
- avm_address  out  ADDR_W+2  byte address = {word_addr, 2'b00}
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  32  write data
- avm_byteenable  out  4  always 4'hF
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data qualifier

## Operation
- States: IDLE, WRITE, READ_REQ, READ_WAIT, DONE.
- IDLE + start: latch base_addr, length and seed. Clear error_count, first_err_addr and pass, and set index i=0. If length==0, go to DONE. Otherwise go to WRITE.
- Pattern: pattern(i) = seed + i, mod 2^32. Word address: word(i) = (base_addr + i) mod 2^ADDR_W, so the region wraps past the top of memory.
- WRITE: avm_write=1, address=word(i), writedata=pattern(i).
  - While avm_waitrequest=1, hold all outputs.
  - When avm_waitrequest=0, the transfer completes. If i==length-1, set i=0 and go to READ_REQ; else increment i.
- READ_REQ: avm_read=1, address=word(i), held while avm_waitrequest=1. When the request is accepted, go to READ_WAIT.
  - Only one read is outstanding at a time.
- READ_WAIT: avm_read=0. On avm_readdatavalid=1, compare avm_readdata with pattern(i).
  - On mismatch: increment error_count, saturating at 0xFFFF. If this is the first mismatch, set first_err_addr=word(i).
  - Then, if i==length-1, go to DONE; else increment i and go to READ_REQ.
- DONE: done=1, pass=(error_count==0), busy=0, then go to IDLE.
- Results (pass, error_count, first_err_addr) hold until the next accepted start.
- start while not in IDLE is ignored. start in the DONE cycle is also ignored.
- avm_readdatavalid outside READ_WAIT is ignored.
- avm_read and avm_write are never high together.
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - All outputs go to 0, except avm_byteenable, which is 4'hF.
  - An in-flight transfer is abandoned and its late readdatavalid is ignored.
- length=2^ADDR_W covers the whole memory exactly once; the index counter is ADDR_W+1 bits wide.

## Timing
- start is sampled at edge E0; the first avm_write is visible in the cycle after E0.
- Zero wait states and read latency 1 (the on-chip memory case):
  - Writes occupy cycles 1..N.
  - Each read takes 2 cycles (request, then data), occupying cycles N+1..3N.
  - done is high in cycle 3N+1.
- Each wait-state cycle adds exactly one cycle. Each extra cycle of read latency adds one cycle per word.
- length=0: done in cycle 1, no bus activity, pass=1.
- All outputs are registered; there is no combinational path from avm_* inputs to avm_* outputs.

## Test plan
- Basic run: base=0x010, length=4, seed=0x1000_0000, zero-wait memory model. Expect writes to byte addresses 0x40, 0x44, 0x48, 0x4C with data 0x10000000..0x10000003. done in cycle 13, pass=1, error_count=0.
- Wrap-around: base=0x3FE, length=4. Expect word addresses 0x3FE, 0x3FF, 0x000, 0x001 in both phases, pass=1.
- Fault injection: the model flips bit 0 on reads of word 0x005 and word 0x007; base=0, length=16. Expect error_count=2, first_err_addr=0x005, pass=0.
- Stalls: waitrequest high for 3 cycles on every access and readdatavalid delayed to 2 cycles; length=2. Expect address and data stable throughout each stall, correct compare, pass=1. start pulses issued mid-run are ignored.
- Edge counts: length=0 gives done at cycle 1 with no avm_read or avm_write. length=1024 covers every word once, pass=1.
- Reset mid-operation: assert reset_n=0 during READ_WAIT. Expect all outputs 0 (byteenable 4'hF) immediately. A stale readdatavalid after release is ignored, and a fresh start completes normally.

Source files
------------

// File: rtl/onchip_mem_test_master_if.sv
// Avalon-MM bus between the memory test master and the on-chip RAM slave.
//   avm_address       byte address, word aligned ({word, 2'b00})
//   avm_read/write    request strobes, held while avm_waitrequest is high
//   avm_writedata     write data
//   avm_byteenable    byte lanes, all enabled
//   avm_waitrequest   slave stall
//   avm_readdata      read data, qualified by avm_readdatavalid
interface onchip_mem_test_master_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W+1:0]   avm_address;
  logic                avm_read;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_waitrequest;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/onchip_mem_test_master.sv
// Memory test engine: writes pattern(i) = seed + i to word (base + i) mod 2^ADDR_W
// for i in 0..length-1, reads every word back one request at a time and counts
// mismatching words.
//   clk, reset_n     clock, asynchronous active-low reset
//   start            one-cycle request, accepted only in IDLE
//   base_addr        first word address (sampled at start)
//   length           word count 0..2^ADDR_W (sampled at start)
//   seed             pattern seed (sampled at start)
//   busy             high while writing or reading
//   done             one-cycle pulse at end of test
//   pass             error_count == 0, valid from the done pulse
//   error_count      mismatching words, saturating at 0xFFFF
//   first_err_addr   word address of the first mismatch
//   avm              Avalon-MM master port
module onchip_mem_test_master #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W:0]           length,
  input  logic [DATA_W-1:0]         seed,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [15:0]               error_count,
  output logic [ADDR_W-1:0]         first_err_addr,
  onchip_mem_test_master_if.master  avm
);

  localparam int unsigned IDX_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_REQ,
    S_READ_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    len_q;
  logic [ADDR_W-1:0]   base_q;
  logic [DATA_W-1:0]   seed_q;
  // word_q and pat_q track word(idx) and pattern(idx) incrementally
  logic [ADDR_W-1:0]   word_q;
  logic [DATA_W-1:0]   pat_q;

  logic                last_c;
  logic                mismatch_c;
  logic [15:0]         err_next_c;

  // Last-word detect and saturating error count for the word being compared
  always_comb begin
    last_c     = (idx == (len_q - IDX_W'(1)));
    mismatch_c = (state == S_READ_WAIT) && avm.avm_readdatavalid &&
                 (avm.avm_readdata != pat_q);
    err_next_c = error_count;
    if (mismatch_c && (error_count != 16'hFFFF)) begin
      err_next_c = error_count + 16'd1;
    end
  end

  // Address and write data come straight from the word/pattern registers
  assign avm.avm_address    = {word_q, 2'b00};
  assign avm.avm_writedata  = pat_q;
  assign avm.avm_byteenable = '1;

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      len_q          <= '0;
      base_q         <= '0;
      seed_q         <= '0;
      word_q         <= '0;
      pat_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      error_count    <= '0;
      first_err_addr <= '0;
      avm.avm_read   <= 1'b0;
      avm.avm_write  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q          <= length;
            base_q         <= base_addr;
            seed_q         <= seed;
            word_q         <= base_addr;
            pat_q          <= seed;
            idx            <= '0;
            error_count    <= '0;
            first_err_addr <= '0;
            // An empty region passes trivially
            pass           <= (length == '0);
            if (length == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              busy          <= 1'b1;
              avm.avm_write <= 1'b1;
              state         <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          if (!avm.avm_waitrequest) begin
            if (last_c) begin
              idx           <= '0;
              word_q        <= base_q;
              pat_q         <= seed_q;
              avm.avm_write <= 1'b0;
              avm.avm_read  <= 1'b1;
              state         <= S_READ_REQ;
            end else begin
              idx    <= idx + IDX_W'(1);
              word_q <= word_q + ADDR_W'(1);
              pat_q  <= pat_q + DATA_W'(1);
            end
          end
        end

        S_READ_REQ: begin
          if (!avm.avm_waitrequest) begin
            avm.avm_read <= 1'b0;
            state        <= S_READ_WAIT;
          end
        end

        S_READ_WAIT: begin
          if (avm.avm_readdatavalid) begin
            error_count <= err_next_c;
            if (mismatch_c && (error_count == '0)) begin
              first_err_addr <= word_q;
            end
            if (last_c) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next_c == '0);
              state <= S_DONE;
            end else begin
              idx          <= idx + IDX_W'(1);
              word_q       <= word_q + ADDR_W'(1);
              pat_q        <= pat_q + DATA_W'(1);
              avm.avm_read <= 1'b1;
              state        <= S_READ_REQ;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_test_master.sv
module tb_onchip_mem_test_master;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic [31:0] seed;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] error_count;
  logic [9:0]  first_err_addr;

  int tests = 0;
  int fails = 0;

  onchip_mem_test_master_if #(.ADDR_W(10), .DATA_W(32)) ifc ();

  onchip_mem_test_master #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .error_count    (error_count),
    .first_err_addr (first_err_addr),
    .avm            (ifc.master)
  );

  always #5 clk = ~clk;

  // ---------------- memory slave model ----------------
  logic [31:0] mem  [DEPTH];
  bit          flip [DEPTH];
  int          ws  = 0;
  int          lat = 1;
  int          wcnt = 0;
  int          rcnt = 0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [31:0] rpend = '0;
  logic        inj_rv;
  logic [11:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [11:0] rd_addr_q [$];
  int          stall_viol = 0;
  int          rw_viol = 0;
  logic        prev_stall = 1'b0;
  logic [11:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b0;

  assign ifc.avm_waitrequest   = (ifc.avm_read || ifc.avm_write) && (wcnt < ws);
  assign ifc.avm_readdatavalid = rvalid | inj_rv;
  assign ifc.avm_readdata      = inj_rv ? 32'h0BAD_0BAD : rdata;

  always @(posedge clk) begin
    if (ifc.avm_read && ifc.avm_write) rw_viol <= rw_viol + 1;
    if (prev_stall && ((ifc.avm_address != prev_addr) || (ifc.avm_read != prev_rd) ||
        (ifc.avm_write != prev_wr) || (ifc.avm_write && (ifc.avm_writedata != prev_data))))
      stall_viol <= stall_viol + 1;
    prev_stall <= ifc.avm_waitrequest;
    prev_addr  <= ifc.avm_address;
    prev_data  <= ifc.avm_writedata;
    prev_rd    <= ifc.avm_read;
    prev_wr    <= ifc.avm_write;

    if ((ifc.avm_read || ifc.avm_write) && ifc.avm_waitrequest) wcnt <= wcnt + 1;
    else wcnt <= 0;

    if (ifc.avm_write && !ifc.avm_waitrequest) begin
      mem[ifc.avm_address[11:2]] <= ifc.avm_writedata;
      wr_addr_q.push_back(ifc.avm_address);
      wr_data_q.push_back(ifc.avm_writedata);
    end

    rvalid <= 1'b0;
    if (rcnt != 0) begin
      rcnt <= rcnt - 1;
      if (rcnt == 1) begin
        rvalid <= 1'b1;
        rdata  <= rpend;
      end
    end
    if (ifc.avm_read && !ifc.avm_waitrequest) begin
      rd_addr_q.push_back(ifc.avm_address);
      if (lat == 1) begin
        rvalid <= 1'b1;
        rdata  <= mem[ifc.avm_address[11:2]] ^ {31'b0, flip[ifc.avm_address[11:2]]};
      end else begin
        rcnt  <= lat - 1;
        rpend <= mem[ifc.avm_address[11:2]] ^ {31'b0, flip[ifc.avm_address[11:2]]};
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":busy"},        32'(busy), 32'd0);
    check({tag, ":done"},        32'(done), 32'd0);
    check({tag, ":pass"},        32'(pass), 32'd0);
    check({tag, ":error_count"}, 32'(error_count), 32'd0);
    check({tag, ":first_err"},   32'(first_err_addr), 32'd0);
    check({tag, ":address"},     32'(ifc.avm_address), 32'd0);
    check({tag, ":read"},        32'(ifc.avm_read), 32'd0);
    check({tag, ":write"},       32'(ifc.avm_write), 32'd0);
    check({tag, ":writedata"},   ifc.avm_writedata, 32'd0);
    check({tag, ":byteenable"},  32'(ifc.avm_byteenable), 32'hF);
  endtask

  // One complete test; expectations come from the region/fault description
  task automatic run(input string name, input int base, input int len, input logic [31:0] sd,
                     input int w, input int l, input bit mid);
    int wb, rb, sv, rv, cyc, exp_cyc, exp_err, exp_first, bad_wr, bad_rd, budget;
    ws = w;
    lat = l;
    exp_err = 0;
    exp_first = 0;
    for (int i = 0; i < len; i++) begin
      if (flip[(base + i) % DEPTH]) begin
        if (exp_err == 0) exp_first = (base + i) % DEPTH;
        exp_err++;
      end
    end
    exp_cyc = (len == 0) ? 1 : len * (1 + w) + len * (1 + w + l) + 1;
    budget  = exp_cyc + 50;
    wb = wr_addr_q.size();
    rb = rd_addr_q.size();
    sv = stall_viol;
    rv = rw_viol;

    @(negedge clk);
    base_addr = 10'(base);
    length    = 11'(len);
    seed      = sd;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = 10'($urandom);
    seed      = $urandom;
    length    = 11'($urandom_range(1, 9));
    cyc = 1;
    if (len > 0) check({name, ":busy_c1"}, 32'(busy), 32'd1);
    while (!done && cyc < budget) begin
      start = mid && (cyc == 2 || cyc == 5);
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check({name, ":done_seen"}, 32'(done), 32'd1);
    check({name, ":done_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({name, ":busy_at_done"}, 32'(busy), 32'd0);
    check({name, ":pass"}, 32'(pass), 32'(exp_err == 0));
    check({name, ":error_count"}, 32'(error_count), 32'(exp_err));
    check({name, ":first_err"}, 32'(first_err_addr), 32'(exp_first));

    // start during DONE (when mid) must be ignored; done is a single pulse
    start = mid;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, ":done_pulse"}, 32'(done), 32'd0);
    check({name, ":idle_after"}, 32'(busy | ifc.avm_read | ifc.avm_write), 32'd0);
    check({name, ":result_held"}, 32'(error_count), 32'(exp_err));

    bad_wr = 0;
    bad_rd = 0;
    for (int i = 0; i < len; i++) begin
      if (wb + i < wr_addr_q.size()) begin
        if (wr_addr_q[wb + i] !== 12'(((base + i) % DEPTH) * 4)) bad_wr++;
        if (wr_data_q[wb + i] !== sd + 32'(i)) bad_wr++;
      end
      if (rb + i < rd_addr_q.size()) begin
        if (rd_addr_q[rb + i] !== 12'(((base + i) % DEPTH) * 4)) bad_rd++;
      end
    end
    check({name, ":write_count"}, 32'(wr_addr_q.size() - wb), 32'(len));
    check({name, ":write_entries"}, 32'(bad_wr), 32'd0);
    check({name, ":read_count"}, 32'(rd_addr_q.size() - rb), 32'(len));
    check({name, ":read_entries"}, 32'(bad_rd), 32'd0);
    check({name, ":stall_stable"}, 32'(stall_viol - sv), 32'd0);
    check({name, ":rw_exclusive"}, 32'(rw_viol - rv), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cyc, b, n, fa, fb;
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    seed      = '0;
    inj_rv    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    run("basic", 16'h010, 4, 32'h1000_0000, 0, 1, 1'b0);
    run("wrap", 10'h3FE, 4, $urandom, 0, 1, 1'b0);

    flip[5] = 1'b1;
    flip[7] = 1'b1;
    run("fault", 0, 16, $urandom, 0, 1, 1'b0);
    flip[5] = 1'b0;
    flip[7] = 1'b0;

    run("stall", $urandom_range(0, 1023), 2, $urandom, 3, 2, 1'b1);
    run("len0", $urandom_range(0, 1023), 0, $urandom, 0, 1, 1'b1);
    run("len1024", $urandom_range(0, 1023), 1024, $urandom, 0, 1, 1'b0);

    // Reset while a read is outstanding
    ws  = 0;
    lat = 2;
    @(negedge clk);
    base_addr = 10'h100;
    length    = 11'd8;
    seed      = $urandom;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!(busy && !ifc.avm_read && !ifc.avm_write) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rst_mid:reached_read_wait", 32'(busy && !ifc.avm_read && !ifc.avm_write), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    inj_rv = 1'b1;
    @(posedge clk);
    #1;
    inj_rv = 1'b0;
    check("rst_mid:stale_busy", 32'(busy), 32'd0);
    check("rst_mid:stale_errcnt", 32'(error_count), 32'd0);
    check("rst_mid:stale_done", 32'(done), 32'd0);
    run("after_reset", 10'h100, 8, $urandom, 0, 1, 1'b0);

    // Randomized regions, wait states, latencies and faults
    for (int r = 0; r < 6; r++) begin
      b  = $urandom_range(0, 1023);
      n  = $urandom_range(1, 40);
      fa = (b + $urandom_range(0, n - 1)) % DEPTH;
      fb = (b + $urandom_range(0, n - 1)) % DEPTH;
      if ($urandom_range(0, 1) == 1) flip[fa] = 1'b1;
      if ($urandom_range(0, 1) == 1) flip[fb] = 1'b1;
      run($sformatf("rand%0d", r), b, n, $urandom, $urandom_range(0, 2),
          $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      flip[fa] = 1'b0;
      flip[fb] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
